// File: rtl/capture_timer_mc.sv
// Multi-channel capture timer: each channel owns a saturating counter, a
// one-entry capture register with valid/ready handshake, and sticky status flags.
module capture_timer_mc #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CAPTURES    = 10
) (
  input  logic                                  clk_i,
  input  logic                                  rst_an_i,
  input  logic [NB_CAPTURES-1:0]                start_in_rising_i,
  input  logic [NB_CAPTURES-1:0]                capture_in_rising_i,
  input  logic [NB_CAPTURES-1:0]                rst_capture_in_rising_i,
  input  logic [NB_CAPTURES-1:0]                mode_cont_i,
  input  logic [NB_CAPTURES-1:0]                capture_ready_i,
  output logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] captured_o,
  output logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] counter_o,
  output logic [NB_CAPTURES-1:0]                capture_valid_o,
  output logic [NB_CAPTURES-1:0]                overflow_o,
  output logic [NB_CAPTURES-1:0]                missed_o,
  output logic [2*NB_CAPTURES-1:0]              state_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_CAPTURED = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  for (genvar g = 0; g < NB_CAPTURES; g++) begin : g_ch
    state_e                    state_q, state_d;
    logic [TIMER_BITWIDTH-1:0] cnt_q, cnt_d;
    logic [TIMER_BITWIDTH-1:0] cap_q, cap_d;
    logic                      valid_q, valid_d;
    logic                      ovf_q, ovf_d;
    logic                      miss_q, miss_d;

    logic start, capture, rst_cap, mode_cont, ready;
    assign start     = start_in_rising_i[g];
    assign capture   = capture_in_rising_i[g];
    assign rst_cap   = rst_capture_in_rising_i[g];
    assign mode_cont = mode_cont_i[g];
    assign ready     = capture_ready_i[g];

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      miss_d  = miss_q;

      if (valid_q && ready) begin
        valid_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
        end
        ST_COUNTING: begin
          if (cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // Start and rst_capture both take precedence over a capture.
          if (capture && !start && !rst_cap) begin
            if (!valid_q || ready) begin
              cap_d   = cnt_q;
              valid_d = 1'b1;
              if (!mode_cont) begin
                state_d = ST_CAPTURED;
              end
            end else begin
              miss_d = 1'b1;
            end
          end
        end
        ST_CAPTURED: begin
          if (rst_cap) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (rst_cap) begin
        cap_d   = '0;
        valid_d = 1'b0;
        miss_d  = 1'b0;
      end

      if (start) begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        miss_d  = 1'b0;
        state_d = ST_COUNTING;
      end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
      if (!rst_an_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        cap_q   <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        miss_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cap_q   <= cap_d;
        valid_q <= valid_d;
        ovf_q   <= ovf_d;
        miss_q  <= miss_d;
      end
    end

    assign counter_o[g*TIMER_BITWIDTH +: TIMER_BITWIDTH]  = cnt_q;
    assign captured_o[g*TIMER_BITWIDTH +: TIMER_BITWIDTH] = cap_q;
    assign capture_valid_o[g]                             = valid_q;
    assign overflow_o[g]                                  = ovf_q;
    assign missed_o[g]                                    = miss_q;
    assign state_o[2*g +: 2]                              = state_q;
  end

endmodule

// File: tb/tb_capture_timer_mc.sv
// Bench for capture_timer_mc: directed scenarios with fixed expectations, then
// random traffic compared every cycle against a per-channel behavioural model.
module tb_capture_timer_mc;
  localparam int W    = 4;
  localparam int N    = 10;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_an;
  logic [N-1:0]   start, cap_in, rst_cap, mode, ready;
  logic [W*N-1:0] captured, counter;
  logic [N-1:0]   valid, ovf, miss;
  logic [2*N-1:0] state;

  always #5 clk = ~clk;

  capture_timer_mc #(.TIMER_BITWIDTH(W), .NB_CAPTURES(N)) dut (
    .clk_i                  (clk),
    .rst_an_i               (rst_an),
    .start_in_rising_i      (start),
    .capture_in_rising_i    (cap_in),
    .rst_capture_in_rising_i(rst_cap),
    .mode_cont_i            (mode),
    .capture_ready_i        (ready),
    .captured_o             (captured),
    .counter_o              (counter),
    .capture_valid_o        (valid),
    .overflow_o             (ovf),
    .missed_o               (miss),
    .state_o                (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: plain integers per channel, 0=idle 1=counting 2=captured.
  int m_cnt[N], m_cap[N], m_st[N];
  bit m_val[N], m_ovf[N], m_miss[N];

  function automatic void model_tick();
    for (int i = 0; i < N; i++) begin
      int nst, ncnt, ncap;
      bit nval, novf, nmiss;
      if (!rst_an) begin
        m_cnt[i] = 0; m_cap[i] = 0; m_st[i] = 0;
        m_val[i] = 0; m_ovf[i] = 0; m_miss[i] = 0;
        continue;
      end
      nst = m_st[i]; ncnt = m_cnt[i]; ncap = m_cap[i];
      nval = m_val[i]; novf = m_ovf[i]; nmiss = m_miss[i];
      if (m_val[i] && ready[i]) nval = 0;
      if (m_st[i] == 3) nst = 0;
      if (m_st[i] == 1) begin
        if (m_cnt[i] == MAXV) novf = 1;
        else ncnt = m_cnt[i] + 1;
        if (cap_in[i] && !start[i] && !rst_cap[i]) begin
          if (!m_val[i] || ready[i]) begin
            ncap = m_cnt[i];
            nval = 1;
            if (!mode[i]) nst = 2;
          end else begin
            nmiss = 1;
          end
        end
      end
      if (rst_cap[i]) begin
        ncap = 0; nval = 0; nmiss = 0;
        if (m_st[i] == 2) nst = 0;
      end
      if (start[i]) begin
        ncnt = 0; novf = 0; nmiss = 0; nst = 1;
      end
      m_st[i] = nst; m_cnt[i] = ncnt; m_cap[i] = ncap;
      m_val[i] = nval; m_ovf[i] = novf; m_miss[i] = nmiss;
    end
  endfunction

  task automatic compare_model();
    logic [63:0] e_cnt, e_cap, e_val, e_ovf, e_miss, e_st;
    e_cnt = '0; e_cap = '0; e_val = '0; e_ovf = '0; e_miss = '0; e_st = '0;
    for (int i = 0; i < N; i++) begin
      e_cnt[i*W +: W] = m_cnt[i][W-1:0];
      e_cap[i*W +: W] = m_cap[i][W-1:0];
      e_st[2*i +: 2]  = m_st[i][1:0];
      e_val[i]        = m_val[i];
      e_ovf[i]        = m_ovf[i];
      e_miss[i]       = m_miss[i];
    end
    check("m_counter",  64'(counter),  e_cnt);
    check("m_captured", 64'(captured), e_cap);
    check("m_valid",    64'(valid),    e_val);
    check("m_overflow", 64'(ovf),      e_ovf);
    check("m_missed",   64'(miss),     e_miss);
    check("m_state",    64'(state),    e_st);
  endtask

  // One clock: model advances on the same inputs, outputs sampled 1 time unit after
  // the edge, then single-cycle pulses are dropped.
  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    compare_model();
    start = '0; cap_in = '0; rst_cap = '0;
  endtask

  initial begin
    rst_an = 1'b0; start = '0; cap_in = '0; rst_cap = '0; mode = '0; ready = '0;
    #2;
    step();
    check("rst_counter", 64'(counter), 64'd0);
    check("rst_state",   64'(state),   64'd0);
    rst_an = 1'b1;

    // One-shot: start at cycle 0, capture when the counter reads 5.
    start[0] = 1'b1; step();
    repeat (5) step();
    cap_in[0] = 1'b1; mode[0] = 1'b0; step();
    check("os_captured", 64'(captured[W-1:0]), 64'd5);
    check("os_valid",    64'(valid[0]),        64'd1);
    check("os_state",    64'(state[1:0]),      64'd2);
    step();
    check("os_hold",     64'(counter[W-1:0]),  64'd6);

    // Continuous with consumer ready: captures at 3 and 8.
    ready[0] = 1'b1; start[0] = 1'b1; rst_cap[0] = 1'b1; step();
    repeat (3) step();
    cap_in[0] = 1'b1; mode[0] = 1'b1; step();
    check("cont_cap3",   64'(captured[W-1:0]), 64'd3);
    repeat (4) step();
    cap_in[0] = 1'b1; step();
    check("cont_cap8",   64'(captured[W-1:0]), 64'd8);
    check("cont_state",  64'(state[1:0]),      64'd1);
    check("cont_missed", 64'(miss[0]),         64'd0);

    // Backpressure: second capture is dropped and flagged.
    ready[0] = 1'b0; start[0] = 1'b1; rst_cap[0] = 1'b1; step();
    repeat (4) step();
    cap_in[0] = 1'b1; step();
    repeat (2) step();
    cap_in[0] = 1'b1; step();
    check("bp_captured", 64'(captured[W-1:0]), 64'd4);
    check("bp_missed",   64'(miss[0]),         64'd1);
    start[0] = 1'b1; step();
    check("bp_clear",    64'(miss[0]),         64'd0);

    // Saturation at all-ones.
    start[0] = 1'b1; step();
    repeat (20) step();
    check("sat_counter", 64'(counter[W-1:0]),  64'd15);
    check("sat_ovf",     64'(ovf[0]),          64'd1);
    start[0] = 1'b1; step();
    check("sat_clr_cnt", 64'(counter[W-1:0]),  64'd0);
    check("sat_clr_ovf", 64'(ovf[0]),          64'd0);

    // Collisions.
    rst_cap[0] = 1'b1; step();
    start[0] = 1'b1; cap_in[0] = 1'b1; step();
    check("col_sc_cnt",  64'(counter[W-1:0]),  64'd0);
    check("col_sc_val",  64'(valid[0]),        64'd0);
    repeat (2) step();
    cap_in[0] = 1'b1; step();
    check("col_pre_cap", 64'(captured[W-1:0]), 64'd2);
    rst_cap[0] = 1'b1; cap_in[0] = 1'b1; step();
    check("col_rc_cap",  64'(captured[W-1:0]), 64'd0);
    check("col_rc_val",  64'(valid[0]),        64'd0);

    // Isolation: park channel 9 in CAPTURED, then hammer channel 0.
    mode[9] = 1'b0; ready[9] = 1'b0;
    start[9] = 1'b1; step();
    repeat (2) step();
    cap_in[9] = 1'b1; step();
    for (int k = 0; k < 8; k++) begin
      start[0] = k[0]; cap_in[0] = 1'b1; rst_cap[0] = (k == 5); mode[0] = k[1];
      step();
      check("iso_cnt9",   64'(counter[9*W +: W]),  64'd3);
      check("iso_cap9",   64'(captured[9*W +: W]), 64'd2);
      check("iso_state9", 64'(state[19:18]),       64'd2);
      check("iso_val9",   64'(valid[9]),           64'd1);
    end

    // Reset mid-count with captures pending.
    start = '1; mode = '1; ready = '0; step();
    repeat (3) step();
    cap_in = '1; step();
    rst_an = 1'b0; cap_in = '1; start = 10'h155; step();
    check("rst_mid_cnt",   64'(counter),  64'd0);
    check("rst_mid_cap",   64'(captured), 64'd0);
    check("rst_mid_flags", 64'({valid, ovf, miss}), 64'd0);
    check("rst_mid_state", 64'(state),    64'd0);
    rst_an = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        start[i]   = ($urandom_range(15) == 0);
        cap_in[i]  = ($urandom_range(3) == 0);
        rst_cap[i] = ($urandom_range(15) == 0);
        mode[i]    = $urandom_range(1);
        ready[i]   = $urandom_range(1);
      end
      rst_an = ($urandom_range(199) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
